// File: rtl/seg_match_pkg.sv
// Shared definitions for the segment pattern matcher: FSM state codes,
// character-class bit positions and width helpers.
package seg_match_pkg;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] START = 3'd1;
   localparam logic [2:0] STOP  = 3'd2;
   localparam logic [2:0] ERROR = 3'd3;
   localparam logic [2:0] MATCH = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE  = IDLE,
      ST_START = START,
      ST_STOP  = STOP,
      ST_ERROR = ERROR,
      ST_MATCH = MATCH
   } state_e;

   // Bit positions inside the class-flag vector produced by the classifier.
   localparam int SMALL     = 0;
   localparam int CAPITAL   = 1;
   localparam int NUMBER    = 2;
   localparam int HEX       = 3;
   localparam int PUNCT     = 4;
   localparam int FIN       = 5;
   localparam int PAREN     = 6;
   localparam int CURLY     = 7;
   localparam int MATH      = 8;
   localparam int WS        = 9;
   localparam int VOWEL     = 10;
   localparam int CONSONANT = 11;
   localparam int OTHER     = 12;

   localparam int N_CLASS_DEF = 13;
   localparam int CNT_W_DEF   = 4;

   function automatic int cls_w(input int n_class);
      return $clog2(n_class);
   endfunction

   function automatic int cnt_max(input int cnt_w);
      return (1 << cnt_w) - 1;
   endfunction

endpackage

// File: rtl/seg_cfg_shadow.sv
// Shadow copy of the pattern configuration, captured when a string starts,
// plus lookup of the current and following segment's class/min/max.
module seg_cfg_shadow
   import seg_match_pkg::*;
#(
   parameter int N_SEG = 4,
   parameter int CNT_W = CNT_W_DEF,
   parameter int CLS_W = cls_w(N_CLASS_DEF)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load,
   input  logic [$clog2(N_SEG):0]     cfg_nseg,
   input  logic [N_SEG*CLS_W-1:0]     cfg_class,
   input  logic [N_SEG*CNT_W-1:0]     cfg_min,
   input  logic [N_SEG*CNT_W-1:0]     cfg_max,
   input  logic [$clog2(N_SEG)-1:0]   seg_idx,
   output logic [$clog2(N_SEG)-1:0]   last_idx,
   output logic [CLS_W-1:0]           cur_class,
   output logic [CNT_W-1:0]           cur_min,
   output logic [CNT_W-1:0]           cur_max,
   output logic [CLS_W-1:0]           nxt_class
);

   localparam int IDX_W  = $clog2(N_SEG);
   localparam int NSEG_W = $clog2(N_SEG) + 1;

   logic [NSEG_W-1:0]      nseg_q, nseg_d, nseg_eff;
   logic [N_SEG*CLS_W-1:0] class_q, class_d;
   logic [N_SEG*CNT_W-1:0] min_q, min_d;
   logic [N_SEG*CNT_W-1:0] max_q, max_d;
   logic [IDX_W-1:0]       nxt_idx;
   logic [CNT_W-1:0]       raw_min;

   always_comb begin
      nseg_d  = nseg_q;
      class_d = class_q;
      min_d   = min_q;
      max_d   = max_q;
      if (load) begin
         nseg_d  = cfg_nseg;
         class_d = cfg_class;
         min_d   = cfg_min;
         max_d   = cfg_max;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         nseg_q  <= '0;
         class_q <= '0;
         min_q   <= '0;
         max_q   <= '0;
      end else begin
         nseg_q  <= nseg_d;
         class_q <= class_d;
         min_q   <= min_d;
         max_q   <= max_d;
      end
   end

   // A zero segment count or zero minimum both mean "one"; counts above N_SEG clamp.
   always_comb begin
      nseg_eff = nseg_q;
      if (nseg_q == '0)
         nseg_eff = NSEG_W'(1);
      else if (nseg_q > NSEG_W'(N_SEG))
         nseg_eff = NSEG_W'(N_SEG);
      last_idx  = IDX_W'(nseg_eff - NSEG_W'(1));
      nxt_idx   = (seg_idx == IDX_W'(N_SEG - 1)) ? '0 : seg_idx + IDX_W'(1);
      cur_class = class_q[seg_idx*CLS_W +: CLS_W];
      nxt_class = class_q[nxt_idx*CLS_W +: CLS_W];
      raw_min   = min_q[seg_idx*CNT_W +: CNT_W];
      cur_min   = (raw_min == '0) ? CNT_W'(1) : raw_min;
      cur_max   = max_q[seg_idx*CNT_W +: CNT_W];
   end

endmodule

// File: rtl/seg_pattern_matcher.sv
// Judges a \0-framed string against up to N_SEG "class k, min..max" segments.
// Optional result statistics are enabled with the SEG_MATCH_STATS_EN macro.
module seg_pattern_matcher
   import seg_match_pkg::*;
#(
   parameter int N_SEG   = 4,
   parameter int N_CLASS = N_CLASS_DEF,
   parameter int CNT_W   = CNT_W_DEF,
   parameter int CLS_W   = $clog2(N_CLASS)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       valid,
   input  logic                       start_stop,
   input  logic [N_CLASS-1:0]         char_class,
   input  logic                       error_verify,
   input  logic [$clog2(N_SEG):0]     cfg_nseg,
   input  logic [N_SEG*CLS_W-1:0]     cfg_class,
   input  logic [N_SEG*CNT_W-1:0]     cfg_min,
   input  logic [N_SEG*CNT_W-1:0]     cfg_max,
   output logic [2:0]                 state,
   output logic [$clog2(N_SEG)-1:0]   seg_idx,
   output logic                       match_valid,
   output logic                       match_ok
`ifdef SEG_MATCH_STATS_EN
   ,
   input  logic                       stat_clr,
   output logic [15:0]                stat_ok,
   output logic [15:0]                stat_err
`endif
);

   localparam int IDX_W = $clog2(N_SEG);
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(cnt_max(CNT_W));

   // Handshake: valid qualifies char_class/start_stop for one cycle; there is
   // no back-pressure, every valid cycle is consumed by the FSM.
   state_e           state_q, state_d;
   logic [IDX_W-1:0] seg_idx_q, seg_idx_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             term_seen_q, term_seen_d;
   logic             match_valid_q, match_valid_d;
   logic             match_ok_q, match_ok_d;

   logic             cfg_load;
   logic [IDX_W-1:0] last_idx;
   logic [CLS_W-1:0] cur_class, nxt_class;
   logic [CNT_W-1:0] cur_min, cur_max;
   logic             hit_cur, hit_nxt, room, min_met, is_last;

   function automatic logic class_hit(input logic [N_CLASS-1:0] flags,
                                      input logic [CLS_W-1:0] idx);
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < N_CLASS; k++)
         if (idx == CLS_W'(k)) hit = flags[k];
      return hit;
   endfunction

   seg_cfg_shadow #(
      .N_SEG (N_SEG),
      .CNT_W (CNT_W),
      .CLS_W (CLS_W)
   ) u_shadow (
      .clk       (clk),
      .rst       (rst),
      .load      (cfg_load),
      .cfg_nseg  (cfg_nseg),
      .cfg_class (cfg_class),
      .cfg_min   (cfg_min),
      .cfg_max   (cfg_max),
      .seg_idx   (seg_idx_q),
      .last_idx  (last_idx),
      .cur_class (cur_class),
      .cur_min   (cur_min),
      .cur_max   (cur_max),
      .nxt_class (nxt_class)
   );

   always_comb begin
      state_d       = state_q;
      seg_idx_d     = seg_idx_q;
      count_d       = count_q;
      term_seen_d   = term_seen_q;
      match_valid_d = 1'b0;
      match_ok_d    = 1'b0;
      cfg_load      = 1'b0;
      hit_cur       = class_hit(char_class, cur_class);
      hit_nxt       = class_hit(char_class, nxt_class);
      room          = (cur_max == '0) || (count_q < cur_max);
      min_met       = (count_q >= cur_min);
      is_last       = (seg_idx_q == last_idx);
      case (state_q)
         ST_IDLE: begin
            if (valid && start_stop) begin
               state_d     = ST_START;
               cfg_load    = 1'b1;
               seg_idx_d   = '0;
               count_d     = '0;
               term_seen_d = 1'b0;
            end
         end
         ST_START: begin
            if (valid) begin
               if (start_stop) begin
                  state_d     = ST_ERROR;
                  term_seen_d = 1'b1;
               end else if (hit_cur) begin
                  state_d   = ST_MATCH;
                  seg_idx_d = '0;
                  count_d   = CNT_W'(1);
               end else begin
                  state_d = ST_ERROR;
               end
            end
         end
         ST_MATCH: begin
            // Greedy: keep extending the current segment before moving on.
            if (valid) begin
               if (hit_cur && room) begin
                  count_d = (count_q == CNT_SAT) ? count_q : count_q + CNT_W'(1);
               end else if (min_met && !is_last && hit_nxt) begin
                  seg_idx_d = seg_idx_q + IDX_W'(1);
                  count_d   = CNT_W'(1);
               end else if (min_met && is_last && start_stop) begin
                  state_d = ST_STOP;
               end else begin
                  state_d     = ST_ERROR;
                  term_seen_d = start_stop;
               end
            end
         end
         ST_STOP: begin
            state_d       = ST_IDLE;
            seg_idx_d     = '0;
            count_d       = '0;
            match_valid_d = 1'b1;
            match_ok_d    = 1'b1;
         end
         ST_ERROR: begin
            if (error_verify || term_seen_q || (valid && start_stop)) begin
               state_d       = ST_IDLE;
               seg_idx_d     = '0;
               count_d       = '0;
               term_seen_d   = 1'b0;
               match_valid_d = 1'b1;
               match_ok_d    = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         seg_idx_q     <= '0;
         count_q       <= '0;
         term_seen_q   <= 1'b0;
         match_valid_q <= 1'b0;
         match_ok_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         seg_idx_q     <= seg_idx_d;
         count_q       <= count_d;
         term_seen_q   <= term_seen_d;
         match_valid_q <= match_valid_d;
         match_ok_q    <= match_ok_d;
      end
   end

   assign state       = state_q;
   assign seg_idx     = seg_idx_q;
   assign match_valid = match_valid_q;
   assign match_ok    = match_ok_q;

`ifdef SEG_MATCH_STATS_EN
   logic [15:0] stat_ok_q, stat_ok_d;
   logic [15:0] stat_err_q, stat_err_d;

   always_comb begin
      stat_ok_d  = stat_ok_q;
      stat_err_d = stat_err_q;
      if (stat_clr) begin
         stat_ok_d  = '0;
         stat_err_d = '0;
      end else if (match_valid_q) begin
         if (match_ok_q) begin
            if (stat_ok_q != 16'hFFFF) stat_ok_d = stat_ok_q + 16'd1;
         end else begin
            if (stat_err_q != 16'hFFFF) stat_err_d = stat_err_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_ok_q  <= '0;
         stat_err_q <= '0;
      end else begin
         stat_ok_q  <= stat_ok_d;
         stat_err_q <= stat_err_d;
      end
   end

   assign stat_ok  = stat_ok_q;
   assign stat_err = stat_err_q;
`endif

endmodule

// File: tb/tb_seg_pattern_matcher.sv
// Bench for seg_pattern_matcher: directed scenarios plus randomized strings,
// with expected verdicts queued at issue time and checked by a monitor.
module tb_seg_pattern_matcher;
   import seg_match_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid = 1'b0;
   logic        start_stop = 1'b0;
   logic [12:0] char_class = '0;
   logic        error_verify = 1'b0;
   logic [2:0]  cfg_nseg = '0;
   logic [15:0] cfg_class = '0;
   logic [15:0] cfg_min = '0;
   logic [15:0] cfg_max = '0;
   logic [2:0]  state;
   logic [1:0]  seg_idx;
   logic        match_valid;
   logic        match_ok;
`ifdef SEG_MATCH_STATS_EN
   logic        stat_clr = 1'b0;
   logic [15:0] stat_ok;
   logic [15:0] stat_err;
`endif

   localparam logic [12:0] CH_A   = (13'd1 << CAPITAL) | (13'd1 << HEX) | (13'd1 << VOWEL);
   localparam logic [12:0] CH_B   = (13'd1 << CAPITAL) | (13'd1 << HEX) | (13'd1 << CONSONANT);
   localparam logic [12:0] CH_DIG = (13'd1 << NUMBER) | (13'd1 << HEX);
   localparam logic [12:0] CH_LC  = (13'd1 << SMALL) | (13'd1 << CONSONANT);
   localparam logic [12:0] CH_PCT = (13'd1 << PUNCT);

   logic [0:0] exp_q[$];
   int n_cmp = 0;
   int n_bad = 0;

   int c_nseg;
   int c_cls[4];
   int c_mn[4];
   int c_mx[4];

   seg_pattern_matcher dut (
      .clk          (clk),
      .rst          (rst),
      .valid        (valid),
      .start_stop   (start_stop),
      .char_class   (char_class),
      .error_verify (error_verify),
      .cfg_nseg     (cfg_nseg),
      .cfg_class    (cfg_class),
      .cfg_min      (cfg_min),
      .cfg_max      (cfg_max),
      .state        (state),
      .seg_idx      (seg_idx),
      .match_valid  (match_valid),
      .match_ok     (match_ok)
`ifdef SEG_MATCH_STATS_EN
      ,
      .stat_clr     (stat_clr),
      .stat_ok      (stat_ok),
      .stat_err     (stat_err)
`endif
   );

   always #5 clk = ~clk;

   // Monitor: every result pulse must correspond to a queued verdict.
   always @(negedge clk) begin
      if (rst && match_valid) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_pulse: match_ok=%0b, no verdict was pending", match_ok);
         end else begin
            logic [0:0] e;
            e = exp_q.pop_front();
            if (match_ok !== e) begin
               n_bad++;
               $display("FAIL verdict: match_ok=%0b, expected %0b", match_ok, e);
            end
         end
      end
   end

   function automatic int eff_min(input int s);
      return (c_mn[s] == 0) ? 1 : c_mn[s];
   endfunction

   function automatic int eff_nseg();
      return (c_nseg == 0) ? 1 : ((c_nseg > 4) ? 4 : c_nseg);
   endfunction

   // Reference: walk the body characters applying the greedy segment rules.
   function automatic bit model_match(input logic [12:0] s[$]);
      int n, seg, cnt;
      n = eff_nseg();
      if (s.size() == 0) return 1'b0;
      if (!s[0][c_cls[0]]) return 1'b0;
      seg = 0;
      cnt = 1;
      for (int k = 1; k < s.size(); k++) begin
         if (s[k][c_cls[seg]] && (c_mx[seg] == 0 || cnt < c_mx[seg]))
            cnt = (cnt < 15) ? cnt + 1 : 15;
         else if (cnt >= eff_min(seg) && seg < n - 1 && s[k][c_cls[seg+1]]) begin
            seg++;
            cnt = 1;
         end else
            return 1'b0;
      end
      return (cnt >= eff_min(seg)) && (seg == n - 1);
   endfunction

   task automatic apply_cfg();
      cfg_nseg = 3'(c_nseg);
      for (int s = 0; s < 4; s++) begin
         cfg_class[s*4 +: 4] = 4'(c_cls[s]);
         cfg_min[s*4 +: 4]   = 4'(c_mn[s]);
         cfg_max[s*4 +: 4]   = 4'(c_mx[s]);
      end
   endtask

   task automatic set_cfg2();
      c_nseg = 2;
      c_cls[0] = CAPITAL; c_mn[0] = 1; c_mx[0] = 2;
      c_cls[1] = NUMBER;  c_mn[1] = 3; c_mx[1] = 3;
      c_cls[2] = 0; c_mn[2] = 0; c_mx[2] = 0;
      c_cls[3] = 0; c_mn[3] = 0; c_mx[3] = 0;
      apply_cfg();
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic send_char(input bit ss, input logic [12:0] f);
      valid      = 1'b1;
      start_stop = ss;
      char_class = f;
      @(posedge clk);
      #1;
      valid      = 1'b0;
      start_stop = 1'b0;
      char_class = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 30) begin
         idle(1);
         t++;
      end
      check(name, exp_q.size(), 0);
      exp_q.delete();
      idle(2);
   endtask

   task automatic send_string(input logic [12:0] s[$], input bit exp, input bit gaps);
      exp_q.push_back(exp);
      send_char(1'b1, '0);
      foreach (s[k]) begin
         send_char(1'b0, s[k]);
         if (gaps) idle($urandom_range(0, 1));
      end
      send_char(1'b1, '0);
      drain("random_drain");
   endtask

   initial begin
      logic [12:0] s[$];
      // Reset state
      idle(2);
      check("rst_state", state, IDLE);
      check("rst_seg_idx", seg_idx, 0);
      check("rst_valid", match_valid, 0);
      check("rst_ok", match_ok, 0);
      @(negedge clk);
      rst = 1'b1;
      idle(2);

      // Clean pass: \0 A B 1 2 3 \0
      set_cfg2();
      exp_q.push_back(1'b1);
      send_char(1'b1, '0);   check("t1_start", state, START);
      send_char(1'b0, CH_A); check("t1_match", state, MATCH);
      send_char(1'b0, CH_B);
      send_char(1'b0, CH_DIG); check("t1_seg1", seg_idx, 1);
      send_char(1'b0, CH_DIG);
      send_char(1'b0, CH_DIG);
      send_char(1'b1, '0);   check("t1_stop", state, STOP);
      idle(1);               check("t1_idle", state, IDLE);
      drain("t1_drain");

      // Terminator before the last segment reaches its minimum
      exp_q.push_back(1'b0);
      send_char(1'b1, '0);
      send_char(1'b0, CH_A);
      send_char(1'b0, CH_DIG);
      send_char(1'b0, CH_DIG);
      send_char(1'b1, '0);   check("t2_error", state, ERROR);
      idle(1);               check("t2_idle", state, IDLE);
      drain("t2_drain");

      // Third capital exceeds max=2; trailing characters must not restart
      exp_q.push_back(1'b0);
      send_char(1'b1, '0);
      send_char(1'b0, CH_A);
      send_char(1'b0, CH_B);
      send_char(1'b0, CH_B); check("t3_error", state, ERROR);
      send_char(1'b0, CH_DIG);
      send_char(1'b0, CH_DIG);
      send_char(1'b0, CH_DIG); check("t3_hold", state, ERROR);
      send_char(1'b1, '0);   check("t3_exit", state, IDLE);
      drain("t3_drain");

      // Unbounded single segment, counter saturates
      c_nseg = 1; c_cls[0] = SMALL; c_mn[0] = 1; c_mx[0] = 0;
      apply_cfg();
      s.delete();
      repeat (20) s.push_back(CH_LC);
      check("t4_model", int'(model_match(s)), 1);
      send_string(s, 1'b1, 1'b0);

      // Config change mid-string has no effect on the string in flight
      set_cfg2();
      exp_q.push_back(1'b1);
      send_char(1'b1, '0);
      send_char(1'b0, CH_A);
      cfg_max[3:0] = 4'd1;
      send_char(1'b0, CH_B);
      send_char(1'b0, CH_DIG);
      send_char(1'b0, CH_DIG);
      send_char(1'b0, CH_DIG);
      send_char(1'b1, '0);
      drain("t5_drain");

      // Reset mid-string: immediate IDLE, no pulse
      set_cfg2();
      send_char(1'b1, '0);
      send_char(1'b0, CH_A);
      send_char(1'b0, CH_B);
      #2 rst = 1'b0;
      #1;
      check("t6_rst_state", state, IDLE);
      check("t6_rst_seg", seg_idx, 0);
      idle(2);
      @(negedge clk);
      rst = 1'b1;
      idle(3);
      check("t6_no_pulse", match_valid, 0);

      // ERROR left via error_verify with valid low
      set_cfg2();
      exp_q.push_back(1'b0);
      send_char(1'b1, '0);
      send_char(1'b0, CH_A);
      send_char(1'b0, CH_PCT); check("t7_error", state, ERROR);
      idle(2);                 check("t7_wait", state, ERROR);
      error_verify = 1'b1;
      idle(1);
      error_verify = 1'b0;
      check("t7_idle", state, IDLE);
      drain("t7_drain");

      // Randomized configurations and strings
      for (int it = 0; it < 60; it++) begin
         c_nseg = $urandom_range(0, 4);
         for (int g = 0; g < 4; g++) begin
            c_cls[g] = $urandom_range(0, 12);
            c_mn[g]  = $urandom_range(0, 3);
            case ($urandom_range(0, 3))
               0:       c_mx[g] = 0;
               1:       c_mx[g] = $urandom_range(1, 15);
               default: c_mx[g] = eff_min(g) + $urandom_range(0, 3);
            endcase
         end
         apply_cfg();
         s.delete();
         for (int g = 0; g < eff_nseg(); g++) begin
            int lo, hi, reps;
            lo = eff_min(g);
            hi = (c_mx[g] == 0) ? lo + 3 : c_mx[g];
            if (hi < lo) hi = lo;
            reps = $urandom_range(lo, hi);
            if ($urandom_range(0, 7) == 0) reps = reps + ($urandom_range(0, 1) ? 1 : -1);
            for (int r = 0; r < reps; r++) begin
               logic [12:0] f;
               f = 13'd1 << c_cls[g];
               if ($urandom_range(0, 3) == 0) f = f | (13'd1 << $urandom_range(0, 12));
               if ($urandom_range(0, 24) == 0) f = 13'($urandom);
               s.push_back(f);
            end
         end
         if (s.size() == 0) s.push_back(13'($urandom));
         send_string(s, model_match(s), 1'b1);
      end

      check("final_queue", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
